// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register-file write-port arbiter.
package reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam int unsigned DEF_NREQ  = 3;
  localparam int unsigned DEF_NREG  = 8;
  localparam int unsigned DEF_AW    = 3;
  localparam int unsigned DEF_WIDTH = 16;

  // Width of a requester index; never zero so a single-requester build still elaborates.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of elig at or above ptr, wrapping modulo NREQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr is always < NREQ, so one subtraction is enough to wrap.
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!valid && elig[idx]) begin
        valid  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register-file write port; registered one-hot grant and write enable.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREG-1:0]       reg_write,
  output logic [WIDTH-1:0]      reg_data,
  output logic                  busy
);

  localparam int unsigned PW = ptr_width(NREQ);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREG-1:0]   reg_write_q, reg_write_d;
  logic [WIDTH-1:0]  reg_data_q, reg_data_d;

  logic [NREQ-1:0]   elig;
  logic [PW-1:0]     pick_ptr;
  logic [PW-1:0]     win;
  logic              win_valid;
  logic [AW-1:0]     win_addr;
  logic [WIDTH-1:0]  win_data;

  // Last cycle's winner only sees its grant at this edge, so it sits out one round.
  assign elig = req & ~grant_q;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  assign pick_ptr = ptr_q;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig   (elig),
    .ptr    (pick_ptr),
    .winner (win),
    .valid  (win_valid)
  );

  assign win_addr = req_addr[int'(win)*AW +: AW];
  assign win_data = req_data[int'(win)*WIDTH +: WIDTH];

  always_comb begin
    state_d     = IDLE;
    ptr_d       = ptr_q;
    grant_d     = '0;
    reg_write_d = '0;
    reg_data_d  = reg_data_q;

    unique case (state_q)
      IDLE:    state_d = win_valid ? WRITE : IDLE;
      WRITE:   state_d = win_valid ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase

    if (win_valid) begin
      grant_d[win] = 1'b1;
      reg_data_d   = win_data;
      // Addresses beyond the bank decode to no enable; the request is still consumed.
      for (int unsigned j = 0; j < NREG; j++) begin
        reg_write_d[j] = (win_addr == AW'(j));
      end
`ifdef ARB_FIXED_PRIO_EN
      ptr_d = '0;
`else
      ptr_d = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      reg_write_q <= '0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      reg_write_q <= reg_write_d;
      reg_data_q  <= reg_data_d;
    end
  end

  assign grant     = grant_q;
  assign reg_write = reg_write_q;
  assign reg_data  = reg_data_q;
  assign busy      = (state_q == WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: two instances (8- and 6-register banks) on shared stimulus,
// checked every cycle against a behavioural arbitration model plus directed literal checks.
module tb_reg_write_arbiter;

  localparam int NREQ  = 3;
  localparam int AW    = 3;
  localparam int WIDTH = 16;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*AW-1:0]    req_addr = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;

  logic [NREQ-1:0]  grant8, grant6;
  logic [7:0]       rw8;
  logic [5:0]       rw6;
  logic [WIDTH-1:0] data8, data6;
  logic             busy8, busy6;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  reg_write_arbiter #(.NREQ(NREQ), .NREG(8), .AW(AW), .WIDTH(WIDTH)) u_dut8 (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .grant     (grant8),
    .reg_write (rw8),
    .reg_data  (data8),
    .busy      (busy8)
  );

  reg_write_arbiter #(.NREQ(NREQ), .NREG(6), .AW(AW), .WIDTH(WIDTH)) u_dut6 (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .grant     (grant6),
    .reg_write (rw6),
    .reg_data  (data6),
    .busy      (busy6)
  );

  always #5 clock = ~clock;

  // Register bank model capturing the 8-register instance at the negedge.
  logic [WIDTH-1:0] bank8 [8];
  always @(negedge clock) begin
    for (int j = 0; j < 8; j++) if (rw8[j]) bank8[j] <= data8;
  end

  // Behavioural model: expected outputs for the cycle following each posedge.
  logic [NREQ-1:0]  exp_grant = '0;
  logic [7:0]       exp_rw8 = '0;
  logic [5:0]       exp_rw6 = '0;
  logic [WIDTH-1:0] exp_data = '0;
  logic             exp_busy = 1'b0;
  int               m_ptr = 0;
  int               m_w;
  int               m_addr;
  logic [NREQ-1:0]  m_elig;

  always @(posedge clock) begin
    if (reset) begin
      exp_grant <= '0;
      exp_rw8   <= '0;
      exp_rw6   <= '0;
      exp_data  <= '0;
      exp_busy  <= 1'b0;
      m_ptr     <= 0;
    end else begin
      m_elig = req & ~exp_grant;
      m_w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (m_w < 0 && m_elig[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
      end
      if (m_w >= 0) begin
        m_addr    = int'(req_addr[m_w*AW +: AW]);
        exp_grant <= NREQ'(1 << m_w);
        exp_rw8   <= (m_addr < 8) ? 8'(1 << m_addr) : 8'd0;
        exp_rw6   <= (m_addr < 6) ? 6'(1 << m_addr) : 6'd0;
        exp_data  <= req_data[m_w*WIDTH +: WIDTH];
        exp_busy  <= 1'b1;
        m_ptr     <= FIXED ? 0 : (m_w + 1) % NREQ;
      end else begin
        exp_grant <= '0;
        exp_rw8   <= '0;
        exp_rw6   <= '0;
        exp_busy  <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("grant8", 32'(grant8), 32'(exp_grant));
      check("grant6", 32'(grant6), 32'(exp_grant));
      check("rw8", 32'(rw8), 32'(exp_rw8));
      check("rw6", 32'(rw6), 32'(exp_rw6));
      check("data8", 32'(data8), 32'(exp_data));
      check("data6", 32'(data6), 32'(exp_data));
      check("busy8", 32'(busy8), 32'(exp_busy));
      check("busy6", 32'(busy6), 32'(exp_busy));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[i*AW +: AW]       = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  logic [NREQ-1:0] exp5;

  initial begin
    // Reset with all requesters active.
    req = 3'b111;
    set_req(0, 3'd1, 16'h0101);
    set_req(1, 3'd2, 16'h0202);
    set_req(2, 3'd3, 16'h0303);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_grant", 32'(grant8), 32'd0);
    check("rst_rw", 32'(rw8), 32'd0);
    check("rst_data", 32'(data8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    reset = 1'b0;
    tick();
    check("first_grant", 32'(grant8), 32'b001);
    req = '0;
    tick();

    // Single write to register 5.
    req = 3'b001;
    set_req(0, 3'd5, 16'hA5A5);
    tick();
    check("t2_grant", 32'(grant8), 32'b001);
    check("t2_rw8", 32'(rw8), 32'b0010_0000);
    check("t2_rw6", 32'(rw6), 32'b10_0000);
    check("t2_data", 32'(data8), 32'hA5A5);
    req = '0;
    tick();
    check("t2_bank5", 32'(bank8[5]), 32'hA5A5);

    // Park ptr at 0 via requester 2, then all three with drop-on-grant.
    req = 3'b100;
    tick();
    req = '0;
    tick();
    req = 3'b111;
    tick();
    check("t3_g0", 32'(grant8), 32'b001);
    req = req & ~grant8;
    tick();
    check("t3_g1", 32'(grant8), 32'b010);
    req = req & ~grant8;
    tick();
    check("t3_g2", 32'(grant8), 32'b100);
    req = req & ~grant8;
    tick();
    check("t3_idle", 32'(busy8), 32'd0);

    // Requester that never drops: granted only every other cycle.
    req = 3'b010;
    tick();
    check("t4_c1", 32'(grant8), 32'b010);
    tick();
    check("t4_c2", 32'(grant8), 32'b000);
    tick();
    check("t4_c3", 32'(grant8), 32'b010);
    tick();
    check("t4_c4", 32'(grant8), 32'b000);
    req = '0;
    tick();

    // Out-of-range address on the 6-register bank.
    req = 3'b010;
    set_req(1, 3'd7, 16'hBEEF);
    tick();
    check("t5_grant", 32'(grant6), 32'b010);
    check("t5_rw6", 32'(rw6), 32'd0);
    check("t5_rw8", 32'(rw8), 32'h80);
    set_req(0, 3'd1, 16'h1111);
    set_req(2, 3'd4, 16'h2222);
    req = 3'b101;
    exp5 = FIXED ? 3'b001 : 3'b100;
    tick();
    check("t5_next", 32'(grant8), 32'(exp5));
    req = req & ~grant8;
    tick();
    req = req & ~grant8;
    tick();

    // Two holders alternate; each is masked right after its own grant.
    req = 3'b110;
    tick();
    check("t6_c1", 32'(grant8), 32'b010);
    tick();
    check("t6_c2", 32'(grant8), 32'b100);
    tick();
    check("t6_c3", 32'(grant8), 32'b010);
    tick();
    check("t6_c4", 32'(grant8), 32'b100);
    req = '0;
    tick();

    // Reset while a write is in flight: the write lands, then everything clears.
    req = 3'b001;
    set_req(0, 3'd2, 16'h1234);
    tick();
    check("mr_grant", 32'(grant8), 32'b001);
    reset = 1'b1;
    req = 3'b011;
    tick();
    check("mr_grant0", 32'(grant8), 32'd0);
    check("mr_busy0", 32'(busy8), 32'd0);
    check("mr_data0", 32'(data8), 32'd0);
    check("mr_bank2", 32'(bank8[2]), 32'h1234);
    reset = 1'b0;
    req = '0;
    tick();

    // Handshake-respecting pseudo-random traffic, checked by the model every cycle.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant8[i] || !req[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          set_req(i, 3'($urandom_range(0, 7)), 16'($urandom));
        end
      end
      tick();
    end
    req = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
